// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared states, size encodings and address-region helpers
// for the byte-bus memory controller.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_IO_WAIT
    } state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LSU
    } owner_t;

    localparam logic [1:0] SIZE_BYTE   = 2'd0;
    localparam logic [1:0] SIZE_HALF   = 2'd1;
    localparam logic [1:0] SIZE_WORD   = 2'd2;
    localparam logic [1:0] IO_REGION   = 2'b11;
    localparam logic [2:0] FETCH_BYTES = 3'd4;

    // Byte count for an LSU size code; the illegal code 3 behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

    // Bytes in the IO window must respect UART back-pressure.
    function automatic logic is_io(input logic [31:0] addr);
        return addr[17:16] == IO_REGION;
    endfunction

endpackage

// File: rtl/mem_byte_asm.sv
// mem_byte_asm: 32-bit read assembly register. Each enabled lane takes the
// incoming byte; a clear starts a new transaction from zero so unused upper
// lanes read back as 0.
module mem_byte_asm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic [3:0]  lane_en,
    input  logic [7:0]  din,
    output logic [31:0] q,
    output logic [31:0] q_next
);

    // Next value: merge the captured byte into its lane, or clear on grant.
    always_comb begin
        q_next = q;
        for (int unsigned k = 0; k < 4; k++) begin
            if (lane_en[k]) begin
                q_next[8*k +: 8] = din;
            end
        end
        if (clr) begin
            q_next = '0;
        end
    end

    // Assembly register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: shares the CPU's 8-bit memory/IO port between instruction fetch
// and the LSU, serialising word/half/byte accesses into byte transactions.
// Build option MEM_CTRL_FETCH_ABORT_EN: a flushed fetch stops issuing
// addresses and returns to IDLE early instead of running to completion.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req_in,
    input  logic [31:0] if_addr_in,
    input  logic        if_flush_in,
    output logic        if_ready_out,
    output logic [31:0] if_inst_out,
    input  logic        lsu_req_in,
    input  logic        lsu_we_in,
    input  logic [1:0]  lsu_size_in,
    input  logic [31:0] lsu_addr_in,
    input  logic [31:0] lsu_wdata_in,
    output logic        lsu_ready_out,
    output logic [31:0] lsu_rdata_out
);

    state_t      state_q, state_n;
    owner_t      owner_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  nbytes_q;
    logic [2:0]  cnt_q;
    logic        flushed_q;
    logic        pend_q;
    logic [1:0]  pend_lane_q;
    logic        if_ready_q;
    logic        lsu_ready_q;
    logic [31:0] if_inst_q;
    logic [31:0] lsu_rdata_q;

    logic        grant_lsu, grant_if, step, fin;
    logic        abort_hold, issuing;
    logic [31:0] cur_addr, next_addr;
    logic [3:0]  lane_en;
    logic [31:0] asm_q, asm_next;

`ifdef MEM_CTRL_FETCH_ABORT_EN
    assign abort_hold = (owner_q == OWN_IF) && flushed_q;
`else
    assign abort_hold = 1'b0;
`endif

    assign cur_addr  = addr_q + {29'd0, cnt_q};
    assign next_addr = cur_addr + 32'd1;
    assign issuing   = (state_q == ST_READ) && (cnt_q < nbytes_q) && !abort_hold;

    assign mem_a    = (issuing || state_q == ST_WRITE || state_q == ST_IO_WAIT) ? cur_addr : '0;
    assign mem_dout = (state_q == ST_WRITE || state_q == ST_IO_WAIT) ? wdata_q[{cnt_q[1:0], 3'b000} +: 8] : '0;
    assign mem_wr   = rdy_in && (state_q == ST_WRITE);

    assign if_ready_out  = if_ready_q;
    assign lsu_ready_out = lsu_ready_q;
    assign if_inst_out   = if_inst_q;
    assign lsu_rdata_out = lsu_rdata_q;

    // Byte presented last active cycle lands in its lane even while paused.
    assign lane_en = pend_q ? (4'b0001 << pend_lane_q) : 4'b0000;

    mem_byte_asm u_asm (
        .clk     (clk_in),
        .rst_n   (rst_n_in),
        .clr     (rdy_in && (grant_lsu || grant_if)),
        .lane_en (lane_en),
        .din     (mem_din),
        .q       (asm_q),
        .q_next  (asm_next)
    );

    // Next-state and control strobes. The owner of a ready pulse has its
    // request masked in the pulse cycle; the IO check is made before a byte's
    // cycle so every IO_WAIT cycle costs exactly one cycle.
    always_comb begin
        state_n   = state_q;
        grant_lsu = 1'b0;
        grant_if  = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_in && !lsu_ready_q) begin
                    grant_lsu = 1'b1;
                    if (!lsu_we_in) begin
                        state_n = ST_READ;
                    end else if (is_io(lsu_addr_in) && io_buffer_full) begin
                        state_n = ST_IO_WAIT;
                    end else begin
                        state_n = ST_WRITE;
                    end
                end else if (if_req_in && !if_ready_q && !if_flush_in) begin
                    grant_if = 1'b1;
                    state_n  = ST_READ;
                end
            end
            ST_READ: begin
                if (issuing) begin
                    step = 1'b1;
                end else begin
                    fin     = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: begin
                step = 1'b1;
                if (cnt_q + 3'd1 == nbytes_q) begin
                    fin     = 1'b1;
                    state_n = ST_IDLE;
                end else if (is_io(next_addr) && io_buffer_full) begin
                    state_n = ST_IO_WAIT;
                end
            end
            ST_IO_WAIT: begin
                if (!io_buffer_full) begin
                    state_n = ST_WRITE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register; frozen while paused.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else if (rdy_in) begin
            state_q <= state_n;
        end
    end

    // Transaction latches, byte counter, capture slot and completion outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            wdata_q     <= '0;
            nbytes_q    <= '0;
            cnt_q       <= '0;
            flushed_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_lane_q <= '0;
            if_ready_q  <= 1'b0;
            lsu_ready_q <= 1'b0;
            if_inst_q   <= '0;
            lsu_rdata_q <= '0;
        end else begin
            pend_q      <= rdy_in && issuing;
            pend_lane_q <= cnt_q[1:0];
            if (rdy_in) begin
                if_ready_q  <= 1'b0;
                lsu_ready_q <= 1'b0;
                if (grant_lsu || grant_if) begin
                    addr_q    <= grant_lsu ? lsu_addr_in : if_addr_in;
                    wdata_q   <= lsu_wdata_in;
                    nbytes_q  <= grant_lsu ? size_bytes(lsu_size_in) : FETCH_BYTES;
                    owner_q   <= grant_lsu ? OWN_LSU : OWN_IF;
                    cnt_q     <= '0;
                    flushed_q <= 1'b0;
                end else begin
                    if (step) begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                    if (state_q == ST_READ && owner_q == OWN_IF && if_flush_in) begin
                        flushed_q <= 1'b1;
                    end
                end
                if (fin) begin
                    if (owner_q == OWN_LSU) begin
                        lsu_ready_q <= 1'b1;
                        if (state_q == ST_READ) begin
                            lsu_rdata_q <= asm_next;
                        end
                    end else if (!flushed_q && !if_flush_in) begin
                        if_ready_q <= 1'b1;
                        if_inst_q  <= asm_next;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks for mem_ctrl against a byte RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ready;
    logic [31:0] if_inst;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_ready;
    logic [31:0] lsu_rdata;

    int total = 0;
    int bad   = 0;
    int unsigned io_writes = 0;
    logic [7:0] ram [logic [31:0]];
    logic [31:0] w;

`ifdef MEM_CTRL_FETCH_ABORT_EN
    localparam int IDLE_AT = 3;
    localparam logic [31:0] FLUSH_T2_A = 32'h0;
`else
    localparam int IDLE_AT = 5;
    localparam logic [31:0] FLUSH_T2_A = 32'h102;
`endif

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full),
        .if_req_in      (if_req),
        .if_addr_in     (if_addr),
        .if_flush_in    (if_flush),
        .if_ready_out   (if_ready),
        .if_inst_out    (if_inst),
        .lsu_req_in     (lsu_req),
        .lsu_we_in      (lsu_we),
        .lsu_size_in    (lsu_size),
        .lsu_addr_in    (lsu_addr),
        .lsu_wdata_in   (lsu_wdata),
        .lsu_ready_out  (lsu_ready),
        .lsu_rdata_out  (lsu_rdata)
    );

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM: one-cycle read latency, writes on mem_wr.
    always @(posedge clk) begin
        mem_din <= ram_rd(mem_a);
        if (mem_wr) begin
            ram[mem_a] = mem_dout;
            if (mem_a == 32'h30000) io_writes = io_writes + 1;
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; io_full = 1'b0;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = '0; lsu_addr = '0; lsu_wdata = '0;
        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h300] = 8'h11; ram[32'h301] = 8'h22; ram[32'h302] = 8'h33; ram[32'h303] = 8'h44;
        ram[32'h1FFF] = 8'hA5; ram[32'h2000] = 8'h3C;

        // Reset state
        nc(); nc(); #1;
        chk("rst_a", mem_a, 0); chk("rst_wr", mem_wr, 0); chk("rst_dout", mem_dout, 0);
        chk("rst_ifr", if_ready, 0); chk("rst_lsur", lsu_ready, 0);
        chk("rst_inst", if_inst, 0); chk("rst_rdata", lsu_rdata, 0);
        nc(); rst_n = 1'b1;

        // Fetch 0x100 -> 0x00000513, ready at G+6
        nc(); if_req = 1'b1; if_addr = 32'h100; #1; chk("f1_g_ready", if_ready, 0);
        for (int i = 0; i < 4; i++) begin
            nc(); #1;
            chk($sformatf("f1_addr%0d", i), mem_a, 32'h100 + i);
            chk("f1_wr", mem_wr, 0);
        end
        nc(); #1; chk("f1_t4_ready", if_ready, 0); chk("f1_t4_a", mem_a, 0);
        nc(); if_req = 1'b0; #1; chk("f1_ready", if_ready, 1); chk("f1_inst", if_inst, 32'h00000513);
        nc(); #1; chk("f1_pulse_end", if_ready, 0); chk("f1_inst_hold", if_inst, 32'h00000513);

        // LSU store word wins over pending fetch; fetch granted in pulse cycle
        w = 32'hDEADBEEF;
        nc(); if_req = 1'b1; if_addr = 32'h300;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h200; lsu_wdata = w; #1;
        for (int i = 0; i < 4; i++) begin
            nc(); #1;
            chk($sformatf("sw_addr%0d", i), mem_a, 32'h200 + i);
            chk("sw_wr", mem_wr, 1);
            chk($sformatf("sw_byte%0d", i), mem_dout, w[8*i +: 8]);
        end
        nc(); lsu_req = 1'b0; #1;
        chk("sw_ready", lsu_ready, 1); chk("sw_if_ready", if_ready, 0); chk("sw_wr_end", mem_wr, 0);
        nc(); #1; chk("f2_first_a", mem_a, 32'h300); chk("sw_pulse_end", lsu_ready, 0);
        for (int i = 1; i < 5; i++) begin
            nc(); #1; chk("f2_busy", if_ready, 0);
        end
        nc(); if_req = 1'b0; #1; chk("f2_ready", if_ready, 1); chk("f2_inst", if_inst, 32'h44332211);

        // Load word back from 0x200
        nc(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_addr = 32'h200; #1;
        for (int i = 0; i < 4; i++) begin
            nc(); #1; chk($sformatf("lw_addr%0d", i), mem_a, 32'h200 + i); chk("lw_wr", mem_wr, 0);
        end
        nc(); #1; chk("lw_t4_ready", lsu_ready, 0);
        nc(); lsu_req = 1'b0; #1; chk("lw_ready", lsu_ready, 1); chk("lw_data", lsu_rdata, 32'hDEADBEEF);

        // IO byte store with UART full for 3 cycles
        nc(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd0; lsu_addr = 32'h30000;
        lsu_wdata = 32'h12345641; io_full = 1'b1; #1;
        nc(); #1; chk("io_t0_wr", mem_wr, 0); chk("io_t0_a", mem_a, 32'h30000);
        nc(); #1; chk("io_t1_wr", mem_wr, 0);
        nc(); io_full = 1'b0; #1; chk("io_t2_wr", mem_wr, 0); chk("io_t2_a", mem_a, 32'h30000);
        chk("io_t2_ready", lsu_ready, 0);
        nc(); #1; chk("io_t3_wr", mem_wr, 1); chk("io_t3_dout", mem_dout, 32'h41); chk("io_t3_a", mem_a, 32'h30000);
        nc(); lsu_req = 1'b0; #1;
        chk("io_ready", lsu_ready, 1); chk("io_wr_end", mem_wr, 0);
        chk("io_count", io_writes, 1); chk("io_data", ram_rd(32'h30000), 32'h41);
        chk("io_rdata_hold", lsu_rdata, 32'hDEADBEEF);

        // Half load across 0x1FFF/0x2000 with rdy low 2 cycles
        nc(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd1; lsu_addr = 32'h1FFF; #1;
        nc(); #1; chk("lh_a0", mem_a, 32'h1FFF);
        nc(); rdy = 1'b0; #1; chk("lh_p1_wr", mem_wr, 0); chk("lh_p1_ready", lsu_ready, 0);
        nc(); #1; chk("lh_p2_a", mem_a, 32'h2000);
        nc(); rdy = 1'b1; #1; chk("lh_a1", mem_a, 32'h2000);
        nc(); #1; chk("lh_t4_a", mem_a, 0); chk("lh_t4_ready", lsu_ready, 0);
        nc(); lsu_req = 1'b0; #1; chk("lh_ready", lsu_ready, 1); chk("lh_data", lsu_rdata, 32'h00003CA5);

        // Flush at T+1 of a fetch; LSU byte load waits for IDLE
        nc(); if_req = 1'b1; if_addr = 32'h100; #1;
        nc(); #1; chk("fl_a0", mem_a, 32'h100);
        nc(); if_flush = 1'b1; if_req = 1'b0;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd0; lsu_addr = 32'h203; #1;
        chk("fl_a1", mem_a, 32'h101);
        for (int k = 2; k <= IDLE_AT + 3; k++) begin
            nc();
            if (k == 2) if_flush = 1'b0;
            if (k == IDLE_AT + 3) lsu_req = 1'b0;
            #1;
            chk($sformatf("fl_noready_t%0d", k), if_ready, 0);
            if (k == 2) chk("fl_t2_a", mem_a, FLUSH_T2_A);
            if (k == IDLE_AT + 1) chk("fl_lsu_a", mem_a, 32'h203);
            if (k == IDLE_AT + 2) chk("fl_lsu_busy", lsu_ready, 0);
            if (k == IDLE_AT + 3) begin
                chk("fl_lsu_ready", lsu_ready, 1);
                chk("fl_lsu_data", lsu_rdata, 32'h000000DE);
            end
        end
        chk("fl_inst_hold", if_inst, 32'h44332211);

        // Reset during T+2 of a word store
        nc(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h400; lsu_wdata = 32'hCAFEF00D; #1;
        nc(); #1; chk("rs_t0_wr", mem_wr, 1); chk("rs_t0_dout", mem_dout, 32'h0D);
        nc(); #1; chk("rs_t1_a", mem_a, 32'h401);
        nc(); rst_n = 1'b0; lsu_req = 1'b0; #1;
        nc(); rst_n = 1'b1; #1;
        chk("rs_a", mem_a, 0); chk("rs_wr", mem_wr, 0); chk("rs_dout", mem_dout, 0);
        chk("rs_lsur", lsu_ready, 0); chk("rs_ifr", if_ready, 0);
        chk("rs_rdata", lsu_rdata, 0); chk("rs_inst", if_inst, 0);
        nc(); #1; chk("rs_next_lsur", lsu_ready, 0); chk("rs_next_a", mem_a, 0); chk("rs_next_wr", mem_wr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
